// File: rtl/cascaded_delay_ctrl_if.sv
// rtl/cascaded_delay_ctrl_if.sv - delay request handshake bundle (valid/channel/value/ready)
interface cascaded_delay_ctrl_if #(
  parameter int CHAN_W = 2,
  parameter int TAP_W  = 9
);
  logic              valid;
  logic [CHAN_W-1:0] channel;
  logic [TAP_W:0]    value;
  logic              ready;

  modport master (
    output valid,
    output channel,
    output value,
    input  ready
  );

  modport slave (
    input  valid,
    input  channel,
    input  value,
    output ready
  );
endinterface

// File: rtl/cascaded_delay_ctrl.sv
// rtl/cascaded_delay_ctrl.sv - cascaded IDELAY/ODELAY load sequencer; optional readback via CASCADED_DELAY_READBACK_EN
module cascaded_delay_ctrl #(
  parameter int NUM_CHANNELS = 4,
  parameter int CHAN_W       = 2,
  parameter int TAP_W        = 9,
  parameter int VTC_WAIT     = 10,
  parameter int SETTLE_WAIT  = 4
) (
  input  logic                            clk,
  input  logic                            reset,
  cascaded_delay_ctrl_if.slave            delay_req,
  output logic                            delay_done,
  output logic                            delay_error,
  output logic [NUM_CHANNELS-1:0]         dly_load,
  output logic [NUM_CHANNELS-1:0]         dly_en_vtc,
  output logic [NUM_CHANNELS*TAP_W-1:0]   dly_master_value,
  output logic [NUM_CHANNELS*TAP_W-1:0]   dly_slave_value
`ifdef CASCADED_DELAY_READBACK_EN
  ,
  input  logic [CHAN_W-1:0]               delay_rd__channel,
  output logic [TAP_W:0]                  delay_rd__value
`endif
);

  // Counter covers the longer of the two wait phases; it counts down to zero.
  localparam int CNT_MAX = (VTC_WAIT > SETTLE_WAIT) ? VTC_WAIT : SETTLE_WAIT;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  // Largest total the pair can realise: both elements at full scale.
  localparam logic [TAP_W:0] SAT_MAX = {{TAP_W{1'b1}}, 1'b0};

  typedef enum logic [2:0] {
    S_IDLE,
    S_VTC_OFF,
    S_LOAD,
    S_SETTLE,
    S_VTC_ON
  } state_t;

  state_t            state;
  state_t            state_next;
  logic [CNT_W-1:0]  cnt;
  logic [CNT_W-1:0]  cnt_next;
  logic [CHAN_W-1:0] ch_q;

  logic              accept;
  logic              chan_ok;
  logic [TAP_W:0]    sat_value;
  logic [TAP_W-1:0]  split_master;
  logic [TAP_W-1:0]  split_slave;

  assign delay_req.ready = (state == S_IDLE);
  assign accept          = delay_req.valid && (state == S_IDLE);
  assign chan_ok         = int'(delay_req.channel) < NUM_CHANNELS;

  // Clamp the requested total, then split it with the odd tap going to the master.
  always_comb begin
    sat_value    = (delay_req.value > SAT_MAX) ? SAT_MAX : delay_req.value;
    split_slave  = sat_value[TAP_W:1];
    split_master = TAP_W'(sat_value - {1'b0, split_slave});
  end

  // Sequence state and phase counter registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  // Next-state logic: VTC off for VTC_WAIT cycles, one load cycle, settle, VTC back on.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    case (state)
      S_IDLE: begin
        if (accept && chan_ok) begin
          state_next = S_VTC_OFF;
          cnt_next   = CNT_W'(VTC_WAIT - 1);
        end
      end
      S_VTC_OFF: begin
        if (cnt == '0) begin
          state_next = S_LOAD;
        end else begin
          cnt_next = cnt - 1'b1;
        end
      end
      S_LOAD: begin
        state_next = S_SETTLE;
        cnt_next   = CNT_W'(SETTLE_WAIT - 1);
      end
      S_SETTLE: begin
        if (cnt == '0) begin
          state_next = S_VTC_ON;
        end else begin
          cnt_next = cnt - 1'b1;
        end
      end
      S_VTC_ON: begin
        state_next = S_IDLE;
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  // Latch the target channel at accept so later input changes cannot disturb the sequence.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ch_q <= '0;
    end else if (accept && chan_ok) begin
      ch_q <= delay_req.channel;
    end
  end

  // Registered per-channel outputs, decoded from the upcoming state so they align with it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      delay_done       <= 1'b0;
      delay_error      <= 1'b0;
      dly_load         <= '0;
      dly_en_vtc       <= '1;
      dly_master_value <= '0;
      dly_slave_value  <= '0;
    end else begin
      delay_error <= accept && !chan_ok;
      delay_done  <= (state_next == S_VTC_ON);
      for (int k = 0; k < NUM_CHANNELS; k++) begin
        dly_load[k] <= (state_next == S_LOAD) && (ch_q == CHAN_W'(k));
        if (accept && chan_ok && (delay_req.channel == CHAN_W'(k))) begin
          dly_en_vtc[k]                        <= 1'b0;
          dly_master_value[k*TAP_W +: TAP_W]   <= split_master;
          dly_slave_value[k*TAP_W +: TAP_W]    <= split_slave;
        end else if ((state_next == S_VTC_ON) && (ch_q == CHAN_W'(k))) begin
          dly_en_vtc[k] <= 1'b1;
        end
      end
    end
  end

`ifdef CASCADED_DELAY_READBACK_EN
  // Readback returns the total taps currently held by the selected pair, zero if out of range.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      delay_rd__value <= '0;
    end else begin
      delay_rd__value <= '0;
      for (int k = 0; k < NUM_CHANNELS; k++) begin
        if (delay_rd__channel == CHAN_W'(k)) begin
          delay_rd__value <= {1'b0, dly_master_value[k*TAP_W +: TAP_W]} +
                             {1'b0, dly_slave_value[k*TAP_W +: TAP_W]};
        end
      end
    end
  end
`endif

endmodule

// File: tb/tb_cascaded_delay_ctrl.sv
// tb/tb_cascaded_delay_ctrl.sv - randomized bench with transaction-level model for cascaded_delay_ctrl
module tb_cascaded_delay_ctrl;

  localparam int NUM = 3;
  localparam int TW  = 9;
  localparam int LAT = 16;

  logic clk;
  logic reset;

  logic                done;
  logic                err;
  logic [NUM-1:0]      load;
  logic [NUM-1:0]      vtc;
  logic [NUM*TW-1:0]   mval;
  logic [NUM*TW-1:0]   sval;
`ifdef CASCADED_DELAY_READBACK_EN
  logic [1:0]          rd_channel;
  logic [TW:0]         rd_value;
`endif

  cascaded_delay_ctrl_if #(.CHAN_W(2), .TAP_W(TW)) req_if ();

  cascaded_delay_ctrl #(
    .NUM_CHANNELS(NUM),
    .CHAN_W(2),
    .TAP_W(TW),
    .VTC_WAIT(10),
    .SETTLE_WAIT(4)
  ) dut (
    .clk(clk),
    .reset(reset),
    .delay_req(req_if),
    .delay_done(done),
    .delay_error(err),
    .dly_load(load),
    .dly_en_vtc(vtc),
    .dly_master_value(mval),
    .dly_slave_value(sval)
`ifdef CASCADED_DELAY_READBACK_EN
    ,
    .delay_rd__channel(rd_channel),
    .delay_rd__value(rd_value)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Model state: time of the last valid accept, its channel, and the values held per channel.
  int  cyc = 0;
  int  m_active = 0;
  int  m_acc = 0;
  int  m_ch = 0;
  int  m_err_cyc = -10;
  int  m_master [NUM];
  int  m_slave  [NUM];
  int  acc_log [$];
  bit  acc_flag = 0;

  int             k_rel;
  int             t_req;
  int             r_ch;
  logic           busy;
  logic           exp_ready;
  logic           exp_done;
  logic           exp_err;
  logic [NUM-1:0] exp_load;
  logic [NUM-1:0] exp_vtc;
  logic [NUM*TW-1:0] exp_mv;
  logic [NUM*TW-1:0] exp_sv;

  // Compare every cycle at the falling edge, then advance the model with this cycle's inputs.
  always @(negedge clk) begin
    if (reset) begin
      m_active  = 0;
      m_err_cyc = -10;
      for (int k = 0; k < NUM; k++) begin
        m_master[k] = 0;
        m_slave[k]  = 0;
      end
    end else begin
      k_rel     = cyc - m_acc;
      busy      = (m_active != 0) && (k_rel >= 1) && (k_rel <= LAT);
      exp_ready = !busy;
      exp_load  = '0;
      exp_vtc   = '1;
      if (busy && k_rel <= LAT - 1) exp_vtc[m_ch] = 1'b0;
      if (busy && k_rel == 11) exp_load[m_ch] = 1'b1;
      exp_done = busy && (k_rel == LAT);
      exp_err  = (cyc == m_err_cyc);
      for (int k = 0; k < NUM; k++) begin
        exp_mv[k*TW +: TW] = TW'(m_master[k]);
        exp_sv[k*TW +: TW] = TW'(m_slave[k]);
      end
      chk("ready",  64'(req_if.ready), 64'(exp_ready));
      chk("done",   64'(done),  64'(exp_done));
      chk("error",  64'(err),   64'(exp_err));
      chk("load",   64'(load),  64'(exp_load));
      chk("en_vtc", 64'(vtc),   64'(exp_vtc));
      chk("master", 64'(mval),  64'(exp_mv));
      chk("slave",  64'(sval),  64'(exp_sv));
      if (req_if.valid && exp_ready) begin
        acc_flag = 1;
        acc_log.push_back(cyc);
        r_ch = int'(req_if.channel);
        if (r_ch < NUM) begin
          t_req = int'(req_if.value);
          if (t_req > 2 * 511) t_req = 2 * 511;
          m_active       = 1;
          m_acc          = cyc;
          m_ch           = r_ch;
          m_slave[r_ch]  = t_req / 2;
          m_master[r_ch] = t_req - t_req / 2;
        end else begin
          m_err_cyc = cyc + 1;
        end
      end
    end
    cyc++;
  end

  // Present a request and hold it until the model reports it was taken.
  task automatic send(input logic [1:0] ch, input logic [TW:0] v);
    bit got;
    #1;
    req_if.valid   = 1'b1;
    req_if.channel = ch;
    req_if.value   = v;
    acc_flag = 0;
    got = 0;
    for (int i = 0; i < 60 && !got; i++) begin
      @(posedge clk);
      if (acc_flag) got = 1;
    end
    if (!got) chk("accept_timeout", 64'(0), 64'(1));
    acc_flag = 0;
  endtask

  task automatic drop();
    #1;
    req_if.valid = 1'b0;
  endtask

  int n0;
  logic [1:0]  rc;
  logic [TW:0] rv;

  initial begin
    reset          = 1'b1;
    req_if.valid   = 1'b0;
    req_if.channel = '0;
    req_if.value   = '0;
`ifdef CASCADED_DELAY_READBACK_EN
    rd_channel = '0;
`endif
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    // Reset state
    @(negedge clk);
    chk("rst_ready",  64'(req_if.ready), 64'(1));
    chk("rst_en_vtc", 64'(vtc), 64'(3'b111));
    chk("rst_load",   64'(load), 64'(0));
    chk("rst_master", 64'(mval), 64'(0));
    chk("rst_slave",  64'(sval), 64'(0));
    chk("rst_done",   64'(done), 64'(0));
    repeat (20) @(posedge clk);

    // Single load on channel 2: 301 -> 151/150, timeline over cycles 1..16
    send(2'd2, 10'd301);
    drop();
    for (int k = 1; k <= LAT; k++) begin
      @(negedge clk);
      chk("sl_master2", 64'(mval[2*TW +: TW]), 64'(151));
      chk("sl_slave2",  64'(sval[2*TW +: TW]), 64'(150));
      chk("sl_en_vtc",  64'(vtc),  (k == LAT) ? 64'(3'b111) : 64'(3'b011));
      chk("sl_load",    64'(load), (k == 11) ? 64'(3'b100) : 64'(0));
      chk("sl_done",    64'(done), (k == LAT) ? 64'(1) : 64'(0));
    end
    @(posedge clk);

    // Saturation and odd split
    send(2'd0, 10'd1023);
    drop();
    repeat (LAT + 1) @(posedge clk);
    @(negedge clk);
    chk("sat_master0", 64'(mval[0 +: TW]), 64'(511));
    chk("sat_slave0",  64'(sval[0 +: TW]), 64'(511));
    @(posedge clk);
    send(2'd0, 10'd1);
    drop();
    repeat (LAT + 1) @(posedge clk);
    @(negedge clk);
    chk("odd_master0", 64'(mval[0 +: TW]), 64'(1));
    chk("odd_slave0",  64'(sval[0 +: TW]), 64'(0));
    @(posedge clk);

    // Bad channel
    send(2'd3, 10'd5);
    drop();
    @(negedge clk);
    chk("bad_error",  64'(err), 64'(1));
    chk("bad_ready",  64'(req_if.ready), 64'(1));
    chk("bad_en_vtc", 64'(vtc), 64'(3'b111));
    chk("bad_load",   64'(load), 64'(0));
    @(negedge clk);
    chk("bad_error_once", 64'(err), 64'(0));
    @(posedge clk);

    // Back-to-back with valid held
    n0 = acc_log.size();
    send(2'd0, 10'd10);
    send(2'd1, 10'd20);
    drop();
    chk("b2b_gap", 64'(acc_log[n0+1] - acc_log[n0]), 64'(LAT + 1));
    repeat (LAT + 2) @(posedge clk);

    // Randomized requests, sometimes leaving valid asserted between them
    for (int i = 0; i < 40; i++) begin
      repeat ($urandom_range(0, 3)) @(posedge clk);
      rc = 2'($urandom_range(0, 3));
      rv = 10'($urandom_range(0, 1023));
      send(rc, rv);
      if ($urandom_range(0, 1) == 0) drop();
    end
    drop();
    repeat (LAT + 4) @(posedge clk);

    // Reset mid-sequence during SETTLE
    send(2'd1, 10'd77);
    drop();
    repeat (12) @(posedge clk);
    #3 reset = 1'b1;
    #1;
    chk("mid_ready",  64'(req_if.ready), 64'(1));
    chk("mid_en_vtc", 64'(vtc), 64'(3'b111));
    chk("mid_load",   64'(load), 64'(0));
    chk("mid_master", 64'(mval), 64'(0));
    chk("mid_slave",  64'(sval), 64'(0));
    chk("mid_done",   64'(done), 64'(0));
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    repeat (8) @(posedge clk);
    send(2'd2, 10'd301);
    drop();
    repeat (LAT + 2) @(posedge clk);

`ifdef CASCADED_DELAY_READBACK_EN
    #1 rd_channel = 2'd2;
    @(posedge clk);
    #1 chk("rd_ch2", 64'(rd_value), 64'(301));
    rd_channel = 2'd3;
    @(posedge clk);
    #1 chk("rd_ch3", 64'(rd_value), 64'(0));
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

endmodule
